// File: rtl/conv_row_sequencer_if.sv
// Job/configuration and datapath-control bundle between a convolution controller
// and the row sequencer that streams BRAM rows through the MAC array.
interface conv_row_sequencer_if #(
    parameter int PIX_W  = 8,
    parameter int KSIZE  = 3,
    parameter int ADDR_W = 8,
    parameter int ROWS_W = 8
);
    logic                           conv_run;
    logic [ROWS_W-1:0]              cfg_rows;
    logic                           cfg_pad;
    logic [ADDR_W-1:0]              cfg_in_base;
    logic [ADDR_W-1:0]              cfg_out_base;
    logic [KSIZE*KSIZE*PIX_W-1:0]   kernel;
    logic                           rd_en;
    logic [ADDR_W-1:0]              rd_addr;
    logic [KSIZE*PIX_W-1:0]         weight;
    logic                           mac_en;
    logic                           mac_clr;
    logic                           wr_en;
    logic [ADDR_W-1:0]              wr_addr;
    logic                           busy;
    logic                           conv_done;
    logic                           cfg_err;

    modport master (
        output conv_run, cfg_rows, cfg_pad, cfg_in_base, cfg_out_base, kernel,
        input  rd_en, rd_addr, weight, mac_en, mac_clr, wr_en, wr_addr, busy, conv_done, cfg_err
    );

    modport slave (
        input  conv_run, cfg_rows, cfg_pad, cfg_in_base, cfg_out_base, kernel,
        output rd_en, rd_addr, weight, mac_en, mac_clr, wr_en, wr_addr, busy, conv_done, cfg_err
    );
endinterface

// File: rtl/conv_row_sequencer.sv
// Row sequencer: reads KSIZE input rows per output row from BRAM1, drives the row-MAC
// array with the matching kernel row, and writes each finished output row to BRAM2.
module conv_row_sequencer #(
    parameter int PIX_W  = 8,
    parameter int KSIZE  = 3,
    parameter int ADDR_W = 8,
    parameter int ROWS_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_row_sequencer_if.slave  bus
);
    localparam int ROW_BITS = KSIZE * PIX_W;
    localparam int TAP_W    = (KSIZE > 1) ? $clog2(KSIZE) : 1;
    localparam int SRC_W    = ROWS_W + TAP_W + 1;
    localparam int HALF     = KSIZE / 2;

    typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

    state_t                       state_reg, state_next;
    logic [TAP_W-1:0]             tap_reg, tap_next;
    logic [ROWS_W-1:0]            row_reg, row_next;
    logic [ROWS_W-1:0]            rows_reg;
    logic [ROWS_W-1:0]            last_row_reg;
    logic                         pad_reg;
    logic                         empty_reg;
    logic [ADDR_W-1:0]            in_base_reg;
    logic [ADDR_W-1:0]            out_base_reg;
    logic [KSIZE*KSIZE*PIX_W-1:0] kernel_reg;
    logic                         mac_en_reg;
    logic                         mac_clr_reg;
    logic [ROW_BITS-1:0]          weight_reg;
    logic [ROW_BITS-1:0]          kernel_rows [KSIZE];

    logic                         job_empty;
    logic [ROWS_W-1:0]            last_row_start;
    logic [SRC_W-1:0]             src_off;
    logic [SRC_W-1:0]             pad_sub;
    logic [SRC_W-1:0]             src_row;
    logic                         src_valid;

    generate
        for (genvar gi = 0; gi < KSIZE; gi++) begin : g_kernel_rows
            assign kernel_rows[gi] = kernel_reg[gi*ROW_BITS +: ROW_BITS];
        end
    endgenerate

    // Job size is judged from the live cfg inputs at the accepting edge.
    always_comb begin
        if (bus.cfg_pad) begin
            job_empty      = (bus.cfg_rows == '0);
            last_row_start = bus.cfg_rows - 1'b1;
        end else begin
            job_empty      = ({1'b0, bus.cfg_rows} < (ROWS_W+1)'(KSIZE));
            last_row_start = bus.cfg_rows - ROWS_W'(KSIZE);
        end
    end

    // Source row = row + tap - offset; computed unsigned so a negative index shows as src_off < pad_sub.
    always_comb begin
        src_off   = SRC_W'(row_reg) + SRC_W'(tap_reg);
        pad_sub   = pad_reg ? SRC_W'(HALF) : '0;
        src_row   = src_off - pad_sub;
        src_valid = (src_off >= pad_sub) && (src_row < SRC_W'(rows_reg));
    end

    always_comb begin
        state_next = state_reg;
        tap_next   = tap_reg;
        row_next   = row_reg;
        case (state_reg)
            IDLE: begin
                if (bus.conv_run) begin
                    tap_next   = '0;
                    row_next   = '0;
                    state_next = job_empty ? DONE : READ;
                end
            end
            READ: begin
                if (tap_reg == TAP_W'(KSIZE-1)) begin
                    tap_next   = '0;
                    state_next = DRAIN;
                end else begin
                    tap_next = tap_reg + 1'b1;
                end
            end
            DRAIN: state_next = WRITE;
            WRITE: begin
                if (row_reg == last_row_reg) begin
                    state_next = DONE;
                end else begin
                    row_next   = row_reg + 1'b1;
                    state_next = READ;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            tap_reg      <= '0;
            row_reg      <= '0;
            rows_reg     <= '0;
            last_row_reg <= '0;
            pad_reg      <= 1'b0;
            empty_reg    <= 1'b0;
            in_base_reg  <= '0;
            out_base_reg <= '0;
            kernel_reg   <= '0;
            mac_en_reg   <= 1'b0;
            mac_clr_reg  <= 1'b0;
            weight_reg   <= '0;
        end else begin
            state_reg <= state_next;
            tap_reg   <= tap_next;
            row_reg   <= row_next;
            if (state_reg == IDLE && bus.conv_run) begin
                rows_reg     <= bus.cfg_rows;
                last_row_reg <= last_row_start;
                pad_reg      <= bus.cfg_pad;
                empty_reg    <= job_empty;
                in_base_reg  <= bus.cfg_in_base;
                out_base_reg <= bus.cfg_out_base;
                kernel_reg   <= bus.kernel;
            end
            // MAC controls trail the read by one cycle to line up with BRAM read latency.
            mac_en_reg  <= (state_reg == READ);
            mac_clr_reg <= (state_reg == READ) && (tap_reg == '0);
            weight_reg  <= (state_reg == READ && src_valid) ? kernel_rows[tap_reg] : '0;
        end
    end

    always_comb begin
        bus.rd_en     = (state_reg == READ) && src_valid;
        bus.rd_addr   = bus.rd_en ? (in_base_reg + ADDR_W'(src_row)) : '0;
        bus.wr_en     = (state_reg == WRITE);
        bus.wr_addr   = bus.wr_en ? (out_base_reg + ADDR_W'(row_reg)) : '0;
        bus.mac_en    = mac_en_reg;
        bus.mac_clr   = mac_clr_reg;
        bus.weight    = weight_reg;
        bus.busy      = (state_reg != IDLE);
        bus.conv_done = (state_reg == DONE);
        bus.cfg_err   = (state_reg == DONE) && empty_reg;
    end
endmodule

// File: doc/conv_row_sequencer.md
Name: conv_row_sequencer

Overview:
- Parametrised successor to the fixed 3x3 input/output controller pair in the convolution top level.
- Latches a run-time job (input row count, input/output BRAM base addresses, kernel, padding mode) and streams input rows from BRAM1 into the row-MAC array (CONV128 class).
- Sequences MAC clear/accumulate with the matching kernel row.
- Writes each finished output row to BRAM2, then signals completion.
- Adds generic kernel size, configurable row count, address wrap-around and optional zero-padding ("same" mode).

Parameters:
- PIX_W, 8: bits per pixel/weight.
- KSIZE, 3: kernel edge length (odd, >=1).
- ADDR_W, 8: BRAM address width (both memories).
- ROWS_W, 8: width of the row-count configuration input.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- conv_run  input  1  start request; sampled only in IDLE.
- cfg_rows  input  ROWS_W  input image row count H; latched on accepted start.
- cfg_pad  input  1  1 = zero-pad top/bottom (output rows = H), 0 = valid (output rows = H-KSIZE+1).
- cfg_in_base  input  ADDR_W  BRAM1 address of input row 0.
- cfg_out_base  input  ADDR_W  BRAM2 address of output row 0.
- kernel  input  KSIZE*KSIZE*PIX_W  kernel; row k, column j at bits [(k*KSIZE+j)*PIX_W +: PIX_W]; latched on accepted start.
- rd_en  output  1  BRAM1 read enable.
- rd_addr  output  ADDR_W  BRAM1 read address.
- weight  output  KSIZE*PIX_W  kernel row for the current MAC step.
- mac_en  output  1  MAC accumulate strobe.
- mac_clr  output  1  with mac_en: accumulator loads the product instead of adding.
- wr_en  output  1  BRAM2 write enable.
- wr_addr  output  ADDR_W  BRAM2 write address.
- busy  output  1  high from accepted start through the done cycle.
- conv_done  output  1  one-cycle completion pulse.
- cfg_err  output  1  one-cycle pulse with conv_done when the job is empty.

Behaviour:
- Reset: every output 0, state IDLE, counters 0. Reset mid-job aborts immediately, with no further reads or writes. rst has priority over a simultaneous conv_run.
- Start: conv_run high in IDLE at edge t latches all cfg_* and kernel, and sets busy. conv_run while busy (including the DONE cycle) is ignored; a new start is accepted from the cycle after DONE.
- Output row count:
  - N = H when cfg_pad = 1.
  - N = H-KSIZE+1 when cfg_pad = 0.
  - If N <= 0 (H < KSIZE unpadded, or H = 0 padded): go to DONE at t+1 with conv_done = cfg_err = 1, and no reads or writes.
- States: IDLE -> READ -> (last read issued) DRAIN -> WRITE -> READ (next row) or DONE -> IDLE.
- Row timing: row r starts at cycle s, with s = t+1 for row 0. Row period is KSIZE+2 cycles with no overlap. Row r ends at s+KSIZE+1 and row r+1 starts at s+KSIZE+2.
  - Cycles s .. s+KSIZE-1, tap k = 0..KSIZE-1:
    - Source row i = r+k-(cfg_pad ? KSIZE/2 : 0).
    - If 0 <= i < H: rd_en = 1, rd_addr = (cfg_in_base + i) mod 2^ADDR_W.
    - Otherwise (padded tap): rd_en = 0.
  - Cycles s+1 .. s+KSIZE: mac_en = 1 and weight = kernel row k for tap k (one-cycle BRAM latency). mac_clr = 1 only at s+1.
    - Padded tap: mac_en = 1 and weight forced to all zeros.
  - Cycle s+KSIZE+1: wr_en = 1, wr_addr = (cfg_out_base + r) mod 2^ADDR_W.
- Completion: after the write of row N-1 at cycle w, the DONE state at w+1 gives conv_done = 1 and busy = 1. The next cycle returns to IDLE with busy = 0.
- Idle values: outside the cycles above, rd_en, mac_en, mac_clr and wr_en are 0. weight is 0 whenever mac_en = 0.
- Counters: sized for ROWS_W. Address arithmetic wraps modulo 2^ADDR_W with no error.

Test Plan:
- Valid mode, KSIZE=3, H=5, in_base=0x10, out_base=0x40, run at t:
  - Reads at t+1..t+3 are 0x10, 0x11, 0x12.
  - Writes at t+5, t+10, t+15 go to 0x40, 0x41, 0x42.
  - conv_done at t+16; busy low at t+17.
- Padded mode, H=4, in_base=0x00:
  - Row 0: rd_en low at t+1, reads 0x00, 0x01; weight at t+2 is 0 with mac_en = 1 and mac_clr = 1.
  - Row 3: reads 0x02, 0x03, third tap padded.
  - 4 writes; conv_done at t+21.
- Empty job, H=2, cfg_pad=0 -> conv_done = cfg_err = 1 at t+1; rd_en and wr_en never asserted.
- Wrap, in_base=0xFE, out_base=0xFF, H=4, unpadded:
  - Row reads are 0xFE, 0xFF, 0x00, then 0xFF, 0x00, 0x01.
  - Writes go to 0xFF, 0x00.
- Busy ignore: conv_run pulsed at t+4 and during DONE -> no effect; a pulse the cycle after DONE starts a new job.
- Reset mid-job: rst at t+7 of the first scenario -> all outputs 0 from t+8, no write to 0x41, conv_done never pulses.
